fu_issue_queue: RTL and testbench
=================================

Name: fu_issue_queue

Overview:
- Producer side of the functional-unit handshake.
- Buffers issued instructions from the reservation station in one small in-order queue per FU class: ALU, MULT, LOAD, STORE.
- Each cycle, drives the FU_PACKET inputs of the FU/CDB block according to the per-FU avail vectors that block returns.
- Sits between RS issue and the FU/CDB block, and decouples RS select from FU structural hazards.

Parameters:
- ISQ_DEPTH, 4, entries per class queue; power of two, at least 2.
- Widths come from shared macros: `N, `NUM_FU_ALU, `NUM_FU_MULT, `NUM_FU_LOAD, `NUM_FU_STORE.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- squash  in  1  mispredict flush; empties all queues
- issue_packet  in  FU_PACKET[`N]  candidate instructions from RS; slot 0 is oldest; uses .valid
- issue_class  in  FU_CLASS[`N]  target class per slot: ALU, MULT, LOAD, STORE
- alu_avail  in  `NUM_FU_ALU  per-FU ready, from FU/CDB
- mult_avail  in  `NUM_FU_MULT  per-FU ready, from FU/CDB
- load_avail  in  `NUM_FU_LOAD  per-FU ready, from FU/CDB
- store_avail  in  `NUM_FU_STORE  per-FU ready, from FU/CDB
- fu_alu_packet  out  FU_PACKET[`NUM_FU_ALU]  to ALUs
- fu_mult_packet  out  FU_PACKET[`NUM_FU_MULT]  to multipliers
- fu_load_packet  out  FU_PACKET[`NUM_FU_LOAD]  to load units
- fu_store_packet  out  FU_PACKET[`NUM_FU_STORE]  to store units
- alu_free, mult_free, load_free, store_free  out  $clog2(ISQ_DEPTH+1) each  registered free-entry count per class, used as RS credits
- overflow  out  1  sticky error flag

Behaviour:
- Clocking: one clock, rising edge. Reset is synchronous and active-high.
- Reset:
  - All queues empty, head and tail pointers 0.
  - Every fu_*_packet is all-zero, so valid=0.
  - *_free = ISQ_DEPTH.
  - overflow = 0.
  - Reset asserted mid-operation discards all contents on the next edge.
- Storage: each class is a circular FIFO with head, tail and count registers. Pointers wrap modulo ISQ_DEPTH.
- Enqueue:
  - Valid issue slots are appended to their class queue in slot order, 0 first.
  - Up to `N entries may target one class in a cycle.
  - An entry enqueued at edge t is eligible for dispatch from cycle t+1. There is no same-cycle bypass, so minimum latency is 1 cycle.
- Dispatch (combinational from registered queue state):
  - For class C, let A = popcount(C_avail).
  - Send P = min(count_C, A) entries.
  - The k-th oldest entry goes to the k-th set bit of C_avail, scanning from index 0 upward.
  - FUs that receive no entry, and all FUs whose avail=0, see an all-zero packet.
  - The P dispatched entries are popped at the next edge.
  - avail must be stable within the cycle; it is never used as a registered input.
- Simultaneous enqueue and pop in one class: count_next = count - P + E, where E = number of enqueued entries. Wrap is handled by the modulo pointers.
- Credits:
  - *_free = ISQ_DEPTH - count, computed from the registered count after the edge.
  - Same-cycle pops are not credited until the following cycle (conservative).
  - RS must not send more than C_free entries of class C in one cycle.
- Overflow:
  - If E exceeds the free entries left after pops, the excess youngest entries are dropped.
  - overflow sets and stays set until reset.
  - A simulation assertion fires on overflow.
- Squash:
  - All four queues empty at the edge.
  - Incoming issue_packet in the same cycle is dropped; squash wins over enqueue.
  - Outputs in the squash cycle still reflect pre-squash heads. The FU block squashes in-flight work itself.
  - The cycle after squash: all outputs invalid, *_free = ISQ_DEPTH.
- Ordering is FIFO within a class only; there is no ordering guarantee across classes.

Decomposition:
- Shared package (sys_defs.svh):
  - typedef enum logic [1:0] FU_CLASS {FU_C_ALU, FU_C_MULT, FU_C_LOAD, FU_C_STORE}
  - macro ISQ_DEPTH
  - FU_PACKET is reused unchanged.
- Sub-module class_queue: parameterized on NUM_FU and ISQ_DEPTH.
  - Holds one FIFO, the enqueue compaction, the avail-to-entry steering and free count.
  - Instantiated four times; the top level only splits issue slots by class and ORs the overflow flags.

Test Plan:
- Reset, then idle: all fu_*_packet.valid=0, every *_free=4, overflow=0 for 5 cycles.
- Basic path: cycle 0 issues 2 ALU packets (tags 5, 6) with alu_avail=all ones.
  - Cycle 1: ALU0 gets tag 5, ALU1 gets tag 6.
  - Cycle 2: ALU queue empty, alu_free=4.
- Backpressure: fill the MULT queue with 4 entries while mult_avail=0.
  - mult_free reads 0 and nothing is dispatched.
  - Raise mult_avail[0] for 4 cycles: entries exit in order, one per cycle, and mult_free climbs 1, 2, 3, 4.
- Sparse avail: 3 LOAD entries queued, load_avail=2'b10.
  - Only FU1 receives the oldest entry and load_free rises by 1.
  - With load_avail=2'b11 on the next cycle, the remaining two go to FU0 then FU1 in age order.
- Squash: 3 STORE and 2 ALU entries queued plus a same-cycle incoming ALU packet, squash=1.
  - Next cycle all outputs are invalid and all free counts are 4; the incoming packet never appears.
- Overflow: ALU queue holds 3, alu_avail=0, RS sends 2 ALU packets.
  - One is enqueued, the youngest is dropped.
  - overflow=1 and stays 1 until reset.

Source files
------------

// File: rtl/fu_issue_queue_pkg.sv
// Shared types and sizing for the FU issue queue: FU class enum, FU packet,
// slot and FU counts.
package fu_issue_queue_pkg;

    localparam int N              = 2;
    localparam int NUM_FU_ALU     = 2;
    localparam int NUM_FU_MULT    = 2;
    localparam int NUM_FU_LOAD    = 2;
    localparam int NUM_FU_STORE   = 1;
    localparam int ISQ_DEPTH_DFLT = 4;

    typedef enum logic [1:0] {
        FU_C_ALU,
        FU_C_MULT,
        FU_C_LOAD,
        FU_C_STORE
    } FU_CLASS;

    typedef struct packed {
        logic        valid;
        logic [7:0]  tag;
        logic [31:0] op;
    } FU_PACKET;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fu_issue_queue_class_queue.sv
// One in-order FIFO for a single FU class: compacts incoming slots onto the
// tail, steers the oldest entries onto the available FUs and reports credits.
module fu_issue_queue_class_queue
    import fu_issue_queue_pkg::*;
#(
    parameter  int NUM_FU    = 2,
    parameter  int ISQ_DEPTH = 4,
    parameter  int NUM_SLOTS = 2,
    localparam int CW        = $clog2(ISQ_DEPTH + 1),
    localparam int PW        = $clog2(ISQ_DEPTH)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_squash,
    input  FU_PACKET [NUM_SLOTS-1:0] i_enq,
    input  logic [NUM_FU-1:0]        i_avail,
    output FU_PACKET [NUM_FU-1:0]    o_fu_packet,
    output logic [CW-1:0]            o_free,
    output logic                     o_overflow
);

    FU_PACKET [ISQ_DEPTH-1:0] r_mem;
    logic [PW-1:0]            r_head;
    logic [PW-1:0]            r_tail;
    logic [CW-1:0]            r_count;
    logic                     r_overflow;

    int                          w_rank;
    int                          w_pop;
    int                          w_room;
    int                          w_seen;
    int                          w_accept;
    logic                        w_ovf;
    logic [PW-1:0]               w_rd_ptr;
    logic [NUM_SLOTS-1:0]        w_wr_en;
    logic [NUM_SLOTS-1:0][PW-1:0] w_wr_ptr;

    // The k-th set avail bit (from index 0) takes the k-th oldest entry.
    always_comb begin
        o_fu_packet = '0;
        w_rank      = 0;
        w_rd_ptr    = r_head;
        for (int f = 0; f < NUM_FU; f++) begin
            if (i_avail[f]) begin
                if (w_rank < int'(r_count)) begin
                    w_rd_ptr       = r_head + PW'(w_rank);
                    o_fu_packet[f] = r_mem[w_rd_ptr];
                end
                w_rank = w_rank + 1;
            end
        end
        w_pop = imin(w_rank, int'(r_count));
    end

    // Room counts this cycle's pops; slots beyond the room are the youngest and drop.
    always_comb begin
        w_room   = ISQ_DEPTH - int'(r_count) + w_pop;
        w_seen   = 0;
        w_wr_en  = '0;
        w_wr_ptr = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (i_enq[s].valid) begin
                if (w_seen < w_room) begin
                    w_wr_en[s]  = 1'b1;
                    w_wr_ptr[s] = r_tail + PW'(w_seen);
                end
                w_seen = w_seen + 1;
            end
        end
        w_accept = imin(w_seen, w_room);
        w_ovf    = (w_seen > w_room);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_squash) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_accept);
            r_count <= CW'(int'(r_count) - w_pop + w_accept);
            if (w_ovf) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_squash) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                if (w_wr_en[s]) r_mem[w_wr_ptr[s]] <= i_enq[s];
            end
        end
    end

    assign o_free     = CW'(ISQ_DEPTH) - r_count;
    assign o_overflow = r_overflow;

    ovf_chk: assert property (@(posedge i_clk) disable iff (i_reset) !(w_ovf && !i_squash))
        else $warning("class queue overflow: youngest entries dropped");

endmodule

// File: rtl/fu_issue_queue.sv
// Per-class issue queues between RS select and the FU/CDB block; splits the
// issue slots by class and gathers the four queues' outputs.
module fu_issue_queue
    import fu_issue_queue_pkg::*;
#(
    parameter  int ISQ_DEPTH = ISQ_DEPTH_DFLT,
    localparam int CW        = $clog2(ISQ_DEPTH + 1)
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_squash,
    input  FU_PACKET [N-1:0]            i_issue_packet,
    input  FU_CLASS  [N-1:0]            i_issue_class,
    input  logic [NUM_FU_ALU-1:0]       i_alu_avail,
    input  logic [NUM_FU_MULT-1:0]      i_mult_avail,
    input  logic [NUM_FU_LOAD-1:0]      i_load_avail,
    input  logic [NUM_FU_STORE-1:0]     i_store_avail,
    output FU_PACKET [NUM_FU_ALU-1:0]   o_fu_alu_packet,
    output FU_PACKET [NUM_FU_MULT-1:0]  o_fu_mult_packet,
    output FU_PACKET [NUM_FU_LOAD-1:0]  o_fu_load_packet,
    output FU_PACKET [NUM_FU_STORE-1:0] o_fu_store_packet,
    output logic [CW-1:0]               o_alu_free,
    output logic [CW-1:0]               o_mult_free,
    output logic [CW-1:0]               o_load_free,
    output logic [CW-1:0]               o_store_free,
    output logic                        o_overflow
);

    FU_PACKET [3:0][N-1:0] w_enq;
    logic     [3:0]        w_ovf;

    // Slot positions are kept so each queue still sees slot order.
    always_comb begin
        w_enq = '0;
        for (int s = 0; s < N; s++) begin
            if (i_issue_packet[s].valid) w_enq[i_issue_class[s]][s] = i_issue_packet[s];
        end
    end

    fu_issue_queue_class_queue #(.NUM_FU(NUM_FU_ALU), .ISQ_DEPTH(ISQ_DEPTH), .NUM_SLOTS(N)) u_alu (
        .i_clk(i_clock), .i_reset(i_reset), .i_squash(i_squash),
        .i_enq(w_enq[FU_C_ALU]), .i_avail(i_alu_avail),
        .o_fu_packet(o_fu_alu_packet), .o_free(o_alu_free), .o_overflow(w_ovf[0])
    );

    fu_issue_queue_class_queue #(.NUM_FU(NUM_FU_MULT), .ISQ_DEPTH(ISQ_DEPTH), .NUM_SLOTS(N)) u_mult (
        .i_clk(i_clock), .i_reset(i_reset), .i_squash(i_squash),
        .i_enq(w_enq[FU_C_MULT]), .i_avail(i_mult_avail),
        .o_fu_packet(o_fu_mult_packet), .o_free(o_mult_free), .o_overflow(w_ovf[1])
    );

    fu_issue_queue_class_queue #(.NUM_FU(NUM_FU_LOAD), .ISQ_DEPTH(ISQ_DEPTH), .NUM_SLOTS(N)) u_load (
        .i_clk(i_clock), .i_reset(i_reset), .i_squash(i_squash),
        .i_enq(w_enq[FU_C_LOAD]), .i_avail(i_load_avail),
        .o_fu_packet(o_fu_load_packet), .o_free(o_load_free), .o_overflow(w_ovf[2])
    );

    fu_issue_queue_class_queue #(.NUM_FU(NUM_FU_STORE), .ISQ_DEPTH(ISQ_DEPTH), .NUM_SLOTS(N)) u_store (
        .i_clk(i_clock), .i_reset(i_reset), .i_squash(i_squash),
        .i_enq(w_enq[FU_C_STORE]), .i_avail(i_store_avail),
        .o_fu_packet(o_fu_store_packet), .o_free(o_store_free), .o_overflow(w_ovf[3])
    );

    assign o_overflow = |w_ovf;

endmodule

// File: tb/tb_fu_issue_queue.sv
// Bench for fu_issue_queue: a queue-per-class reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_fu_issue_queue;
    import fu_issue_queue_pkg::*;

    localparam int DEPTH = ISQ_DEPTH_DFLT;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        sq;
    FU_PACKET [N-1:0]            ipk;
    FU_CLASS  [N-1:0]            icl;
    logic [NUM_FU_ALU-1:0]       aa;
    logic [NUM_FU_MULT-1:0]      ma;
    logic [NUM_FU_LOAD-1:0]      la;
    logic [NUM_FU_STORE-1:0]     sa;
    FU_PACKET [NUM_FU_ALU-1:0]   oa;
    FU_PACKET [NUM_FU_MULT-1:0]  om;
    FU_PACKET [NUM_FU_LOAD-1:0]  ol;
    FU_PACKET [NUM_FU_STORE-1:0] os;
    logic [2:0]                  fa, fm, fl, fs;
    logic                        ovf;

    fu_issue_queue #(.ISQ_DEPTH(DEPTH)) dut (
        .i_clock(clk), .i_reset(rst), .i_squash(sq),
        .i_issue_packet(ipk), .i_issue_class(icl),
        .i_alu_avail(aa), .i_mult_avail(ma), .i_load_avail(la), .i_store_avail(sa),
        .o_fu_alu_packet(oa), .o_fu_mult_packet(om), .o_fu_load_packet(ol), .o_fu_store_packet(os),
        .o_alu_free(fa), .o_mult_free(fm), .o_load_free(fl), .o_store_free(fs),
        .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    FU_PACKET mq[4][$];
    bit       m_ovf = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    function automatic int nfu(input int c);
        case (c)
            0:       return NUM_FU_ALU;
            1:       return NUM_FU_MULT;
            2:       return NUM_FU_LOAD;
            default: return NUM_FU_STORE;
        endcase
    endfunction

    function automatic logic [1:0] avail_of(input int c);
        case (c)
            0:       return aa;
            1:       return ma;
            2:       return la;
            default: return {1'b0, sa};
        endcase
    endfunction

    function automatic FU_PACKET dut_pkt(input int c, input int f);
        case (c)
            0:       return oa[f[0]];
            1:       return om[f[0]];
            2:       return ol[f[0]];
            default: return os[0];
        endcase
    endfunction

    function automatic logic [2:0] dut_free(input int c);
        case (c)
            0:       return fa;
            1:       return fm;
            2:       return fl;
            default: return fs;
        endcase
    endfunction

    // Reference model: expected outputs from the queues, then the effect of the coming edge.
    int         k;
    int         pops[4];
    logic [1:0] av;
    FU_PACKET   exp_p;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < 4; c++) begin
                av = avail_of(c);
                k  = 0;
                for (int f = 0; f < nfu(c); f++) begin
                    exp_p = '0;
                    if (av[f]) begin
                        if (k < mq[c].size()) exp_p = mq[c][k];
                        k++;
                    end
                    chk($sformatf("model pkt c%0d f%0d", c, f), 64'(dut_pkt(c, f)), 64'(exp_p));
                end
                pops[c] = (k < mq[c].size()) ? k : mq[c].size();
                chk($sformatf("model free c%0d", c), 64'(dut_free(c)), 64'(DEPTH - mq[c].size()));
            end
            chk("model overflow", 64'(ovf), 64'(m_ovf));
            if (rst) begin
                for (int c = 0; c < 4; c++) mq[c].delete();
                m_ovf = 1'b0;
            end else if (sq) begin
                for (int c = 0; c < 4; c++) mq[c].delete();
            end else begin
                for (int c = 0; c < 4; c++)
                    for (int p = 0; p < pops[c]; p++) void'(mq[c].pop_front());
                for (int s = 0; s < N; s++) begin
                    if (ipk[s].valid) begin
                        if (mq[int'(icl[s])].size() < DEPTH) mq[int'(icl[s])].push_back(ipk[s]);
                        else m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ipk = '0;
        for (int s = 0; s < N; s++) icl[s] = FU_C_ALU;
    endtask

    task automatic iss(input int s, input FU_CLASS c, input int tg);
        ipk[s].valid = 1'b1;
        ipk[s].tag   = 8'(tg);
        ipk[s].op    = 32'(tg * 7 + 1);
        icl[s]       = c;
    endtask

    int tg;
    int fr[4];
    int rc;

    initial begin
        rst = 1'b1; sq = 1'b0; aa = '0; ma = '0; la = '0; sa = '0;
        clr();
        tick(); tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;

        // reset then idle
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            chk("idle alu_free", 64'(fa), 4); chk("idle mult_free", 64'(fm), 4);
            chk("idle load_free", 64'(fl), 4); chk("idle store_free", 64'(fs), 4);
            chk("idle overflow", 64'(ovf), 0); chk("idle alu0 valid", 64'(oa[0].valid), 0);
        end

        // basic path
        iss(0, FU_C_ALU, 5); iss(1, FU_C_ALU, 6); aa = 2'b11;
        tick(); clr(); #1;
        chk("basic alu0 valid", 64'(oa[0].valid), 1); chk("basic alu0 tag", 64'(oa[0].tag), 5);
        chk("basic alu1 tag", 64'(oa[1].tag), 6); chk("basic alu_free", 64'(fa), 2);
        tick(); #1;
        chk("basic drained free", 64'(fa), 4); chk("basic drained valid", 64'(oa[0].valid), 0);
        aa = '0;

        // backpressure
        iss(0, FU_C_MULT, 10); iss(1, FU_C_MULT, 11); tick();
        iss(0, FU_C_MULT, 12); iss(1, FU_C_MULT, 13); tick();
        clr(); #1;
        chk("bp full free", 64'(fm), 0); chk("bp mult0 valid", 64'(om[0].valid), 0);
        ma = 2'b01; #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp mult0 tag", 64'(om[0].tag), 64'(10 + i)); chk("bp mult0 valid", 64'(om[0].valid), 1);
            chk("bp mult1 valid", 64'(om[1].valid), 0); chk("bp mult_free", 64'(fm), 64'(i));
            tick(); #1;
        end
        chk("bp final free", 64'(fm), 4); chk("bp final valid", 64'(om[0].valid), 0);
        ma = '0;

        // sparse avail
        iss(0, FU_C_LOAD, 20); iss(1, FU_C_LOAD, 21); tick();
        clr(); iss(0, FU_C_LOAD, 22); tick();
        clr(); la = 2'b10; #1;
        chk("sparse load1 tag", 64'(ol[1].tag), 20); chk("sparse load0 valid", 64'(ol[0].valid), 0);
        chk("sparse free before", 64'(fl), 1);
        tick(); la = 2'b11; #1;
        chk("sparse free after", 64'(fl), 2); chk("sparse load0 tag", 64'(ol[0].tag), 21);
        chk("sparse load1 tag2", 64'(ol[1].tag), 22);
        tick(); la = '0; #1;
        chk("sparse drained", 64'(fl), 4);

        // squash
        iss(0, FU_C_STORE, 30); iss(1, FU_C_STORE, 31); tick();
        iss(0, FU_C_STORE, 32); iss(1, FU_C_ALU, 40); tick();
        clr(); iss(0, FU_C_ALU, 41); tick();
        clr(); sq = 1'b1; iss(0, FU_C_ALU, 42); sa = 1'b1; aa = 2'b11; #1;
        chk("sq pre store tag", 64'(os[0].tag), 30); chk("sq pre alu0 tag", 64'(oa[0].tag), 40);
        chk("sq pre alu1 tag", 64'(oa[1].tag), 41); chk("sq pre store_free", 64'(fs), 1);
        chk("sq pre alu_free", 64'(fa), 2);
        tick(); sq = 1'b0; clr(); #1;
        chk("sq store_free", 64'(fs), 4); chk("sq alu_free", 64'(fa), 4);
        chk("sq store valid", 64'(os[0].valid), 0); chk("sq alu0 valid", 64'(oa[0].valid), 0);
        chk("sq alu1 valid", 64'(oa[1].valid), 0);
        tick(); #1;
        chk("sq no ghost", 64'(oa[0].valid), 0);
        aa = '0; sa = '0;

        // overflow
        iss(0, FU_C_ALU, 50); iss(1, FU_C_ALU, 51); tick();
        clr(); iss(0, FU_C_ALU, 52); tick();
        iss(0, FU_C_ALU, 53); iss(1, FU_C_ALU, 54); #1;
        chk("ovf pre free", 64'(fa), 1); chk("ovf pre flag", 64'(ovf), 0);
        tick(); clr(); #1;
        chk("ovf flag", 64'(ovf), 1); chk("ovf full", 64'(fa), 0);
        aa = 2'b11; #1;
        chk("ovf alu0 tag a", 64'(oa[0].tag), 50); chk("ovf alu1 tag a", 64'(oa[1].tag), 51);
        tick(); #1;
        chk("ovf alu0 tag b", 64'(oa[0].tag), 52); chk("ovf alu1 tag b", 64'(oa[1].tag), 53);
        tick(); #1;
        chk("ovf dropped", 64'(oa[0].valid), 0); chk("ovf drained", 64'(fa), 4);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("ovf sticky", 64'(ovf), 1);
        end
        aa = '0;

        // reset mid-operation
        iss(0, FU_C_ALU, 60); iss(1, FU_C_MULT, 61); tick();
        clr(); rst = 1'b1; tick();
        rst = 1'b0; aa = 2'b11; ma = 2'b11; #1;
        chk("rst alu_free", 64'(fa), 4); chk("rst mult_free", 64'(fm), 4);
        chk("rst overflow", 64'(ovf), 0); chk("rst alu0 valid", 64'(oa[0].valid), 0);
        chk("rst mult0 valid", 64'(om[0].valid), 0);

        // credit-respecting mixed traffic, exercises wrap and same-cycle push/pop
        tg = 100;
        for (int cyc = 0; cyc < 80; cyc++) begin
            for (int c = 0; c < 4; c++) fr[c] = DEPTH - mq[c].size();
            clr();
            for (int s = 0; s < N; s++) begin
                if ($urandom_range(0, 3) != 0) begin
                    rc = int'($urandom_range(0, 3));
                    if (fr[rc] > 0) begin
                        fr[rc]--;
                        iss(s, FU_CLASS'(rc), tg);
                        tg++;
                    end
                end
            end
            aa = 2'($urandom); ma = 2'($urandom); la = 2'($urandom); sa = 1'($urandom);
            sq = ($urandom_range(0, 19) == 0);
            tick();
        end
        clr(); sq = 1'b0; aa = 2'b11; ma = 2'b11; la = 2'b11; sa = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("end alu_free", 64'(fa), 4); chk("end overflow", 64'(ovf), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
